// File: rtl/dot4_mul_sequencer.sv
// Fixed-point 4-term dot product sequencer: latches eight operands, then drives one
// shared external multiplier over four cycles and accumulates floor-truncated products.
module dot4_mul_sequencer #(
    parameter int W    = 6,
    parameter int FRAC = 6,
    parameter int RW   = 2*W - FRAC + 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_in,
    input  logic [W-1:0]    num1,
    input  logic [W-1:0]    num2,
    input  logic [W-1:0]    num3,
    input  logic [W-1:0]    num4,
    input  logic [W-1:0]    num5,
    input  logic [W-1:0]    num6,
    input  logic [W-1:0]    num7,
    input  logic [W-1:0]    num8,
    output logic            busy,
    output logic            mul_en,
    output logic [W-1:0]    mul_a,
    output logic [W-1:0]    mul_b,
    input  logic [2*W-1:0]  mul_p,
    output logic            en_out,
    output logic [RW-1:0]   result
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [RW-1:0]   r_acc;
    logic [RW-1:0]   r_result;
    logic            r_en_out;
    logic [W-1:0]    r_op_a [0:3];
    logic [W-1:0]    r_op_b [0:3];

    logic [RW-1:0]   w_sum;
    logic [W-1:0]    w_mul_a;
    logic [W-1:0]    w_mul_b;

    // Truncation is per term: drop the FRAC fraction bits of each product before adding.
    assign w_sum = r_acc + RW'(mul_p >> FRAC);

    // Operand select for the shared multiplier; only registered copies ever reach it.
    always_comb begin
        w_mul_a = {W{1'b0}};
        w_mul_b = {W{1'b0}};
        if (r_state == S_MUL) begin
            case (r_idx)
                2'd0: begin w_mul_a = r_op_a[0]; w_mul_b = r_op_b[0]; end
                2'd1: begin w_mul_a = r_op_a[1]; w_mul_b = r_op_b[1]; end
                2'd2: begin w_mul_a = r_op_a[2]; w_mul_b = r_op_b[2]; end
                2'd3: begin w_mul_a = r_op_a[3]; w_mul_b = r_op_b[3]; end
                default: begin w_mul_a = {W{1'b0}}; w_mul_b = {W{1'b0}}; end
            endcase
        end else begin
            w_mul_a = {W{1'b0}};
            w_mul_b = {W{1'b0}};
        end
    end

    // Sequencer FSM: accept in IDLE, four accumulate cycles in MUL, publish on the last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_acc    <= {RW{1'b0}};
            r_result <= {RW{1'b0}};
            r_en_out <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_op_a[i] <= {W{1'b0}};
                r_op_b[i] <= {W{1'b0}};
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_en_out <= 1'b0;
                    if (en_in) begin
                        r_op_a[0] <= num1;
                        r_op_b[0] <= num2;
                        r_op_a[1] <= num3;
                        r_op_b[1] <= num4;
                        r_op_a[2] <= num5;
                        r_op_b[2] <= num6;
                        r_op_a[3] <= num7;
                        r_op_b[3] <= num8;
                        r_acc     <= {RW{1'b0}};
                        r_idx     <= 2'd0;
                        r_state   <= S_MUL;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc <= w_sum;
                    if (r_idx == 2'd3) begin
                        r_result <= w_sum;
                        r_en_out <= 1'b1;
                        r_idx    <= 2'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_en_out <= 1'b0;
                        r_idx    <= r_idx + 2'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_idx    <= 2'd0;
                    r_en_out <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = (r_state == S_MUL);
    assign mul_en = (r_state == S_MUL);
    assign mul_a  = w_mul_a;
    assign mul_b  = w_mul_b;
    assign en_out = r_en_out;
    assign result = r_result;

endmodule

// File: tb/tb_dot4_mul_sequencer.sv
// Randomized and directed bench for dot4_mul_sequencer against a transaction-level
// model: each accepted operand set yields the sum of floor(a*b/2^FRAC) four edges later.
module tb_dot4_mul_sequencer;
    localparam int W    = 6;
    localparam int FRAC = 6;
    localparam int RW   = 2*W - FRAC + 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en_in = 1'b0;
    logic [W-1:0]    num [1:8];
    logic            busy, mul_en, en_out;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_p;
    logic [RW-1:0]   result;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // The shared multiplier the sequencer expects to find outside it.
    assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    dot4_mul_sequencer #(.W(W), .FRAC(FRAC), .RW(RW)) dut (
        .clk(clk), .rst(rst), .en_in(en_in),
        .num1(num[1]), .num2(num[2]), .num3(num[3]), .num4(num[4]),
        .num5(num[5]), .num6(num[6]), .num7(num[7]), .num8(num[8]),
        .busy(busy), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .en_out(en_out), .result(result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a transaction occupies four cycles after its accept edge.
    int        m_left = 0;
    int        m_k = 0;
    int        m_pend = 0;
    int        m_result = 0;
    bit        m_en_out = 1'b0;
    int        m_a [4];
    int        m_b [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_k = 0; m_result = 0; m_en_out = 1'b0;
        end else begin
            m_en_out = 1'b0;
            if (m_left > 0) begin
                m_left--;
                m_k++;
                if (m_left == 0) begin
                    m_result = m_pend;
                    m_en_out = 1'b1;
                end
            end else if (en_in) begin
                m_pend = 0;
                for (int k = 0; k < 4; k++) begin
                    m_a[k] = int'(num[2*k+1]);
                    m_b[k] = int'(num[2*k+2]);
                    m_pend += (m_a[k] * m_b[k]) / (1 << FRAC);
                end
                m_left = 4;
                m_k = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("busy",   32'(busy),   32'(m_left > 0));
            chk("mul_en", 32'(mul_en), 32'(m_left > 0));
            chk("mul_a",  32'(mul_a),  (m_left > 0) ? 32'(m_a[m_k]) : 32'd0);
            chk("mul_b",  32'(mul_b),  (m_left > 0) ? 32'(m_b[m_k]) : 32'd0);
            chk("en_out", 32'(en_out), 32'(m_en_out));
            chk("result", 32'(result), 32'(m_result));
        end
    end

    int busy_cnt = 0;
    int en_out_cnt = 0;
    bit prev_busy = 1'b0;
    int rise_q [$];

    // Observes DUT activity for the directed timing checks.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (en_out) en_out_cnt++;
        if (busy && !prev_busy) rise_q.push_back(cyc);
        prev_busy = busy;
    end

    task automatic set_all(input int v);
        for (int i = 1; i <= 8; i++) num[i] = W'(v);
    endtask

    task automatic rand_ops();
        for (int i = 1; i <= 8; i++) num[i] = W'($urandom_range(0, (1 << W) - 1));
    endtask

    task automatic wait_en_out(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (en_out) found = 1'b1;
        end
        if (!found) begin
            n_vec++; n_bad++;
            $display("FAIL en_out_timeout at cycle %0d: got no pulse, expected one", cyc);
        end
    endtask

    task automatic one_shot(input string name, input int exp_res);
        bit found;
        @(posedge clk); #1;
        busy_cnt = 0;
        en_in = 1'b1;
        @(posedge clk); #1;
        en_in = 1'b0;
        wait_en_out(found);
        if (found) chk(name, 32'(result), 32'(exp_res));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    endtask

    initial begin
        bit found;
        int n_done;
        set_all(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_mul_a",  32'(mul_a),  32'd0);
        chk("rst_en_out", 32'(en_out), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        set_all(32);
        one_shot("half_x4", 64);
        set_all(63);
        one_shot("max_x4", 248);
        set_all(0);
        num[1] = 6'd1; num[2] = 6'd63; num[3] = 6'd63; num[4] = 6'd2;
        one_shot("per_term_floor", 1);

        // en_in held high; operands scrambled every cycle including during MUL.
        @(posedge clk); #1;
        rise_q.delete();
        rand_ops();
        en_in = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40 && n_done < 3; i++) begin
            @(negedge clk);
            if (en_out) n_done++;
            if (n_done == 3) en_in = 1'b0;
            rand_ops();
        end
        chk("held_results", 32'(n_done), 32'd3);
        chk("held_accepts", 32'(rise_q.size()), 32'd3);
        for (int i = 1; i < rise_q.size(); i++)
            chk("accept_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd5);

        // en_in pulse while busy is dropped.
        repeat (2) @(posedge clk);
        #1;
        busy_cnt = 0; en_out_cnt = 0;
        rand_ops();
        en_in = 1'b1;
        @(posedge clk); #1; en_in = 1'b0;
        @(posedge clk); #1; en_in = 1'b1;
        @(posedge clk); #1; en_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_pulse_en_outs", 32'(en_out_cnt), 32'd1);
        chk("busy_pulse_busy",    32'(busy_cnt),   32'd4);

        // Asynchronous reset in the idx=2 cycle discards the computation.
        set_all(63);
        en_in = 1'b1;
        @(posedge clk); #1; en_in = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_mul_en", 32'(mul_en), 32'd0);
        chk("arst_mul_a",  32'(mul_a),  32'd0);
        chk("arst_mul_b",  32'(mul_b),  32'd0);
        chk("arst_en_out", 32'(en_out), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        en_out_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_no_en_out", 32'(en_out_cnt), 32'd0);
        set_all(32);
        num[7] = 6'd63; num[8] = 6'd63;
        one_shot("post_rst_result", 16 + 16 + 16 + 62);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            en_in = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) set_all($urandom_range(0, 1) ? 63 : 0);
            else rand_ops();
        end
        en_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
